// File: rtl/id_ex_operand_stage.sv
// ============================================================================
//  Module   : id_ex_operand_stage
//  Purpose  : ID/EX register feeding the ALU, with RAW forwarding or
//             hazard stalls and a saturating bubble counter.
//             Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_operand_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    id_valid_i,
    input  logic [3:0]              id_alu_operation_i,
    input  logic [REG_ADDR_W-1:0]   id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0]   id_rt_addr_i,
    input  logic                    id_rt_used_i,
    input  logic [REG_ADDR_W-1:0]   id_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   id_rs_data_i,
    input  logic [DATA_WIDTH-1:0]   id_rt_data_i,
    input  logic [DATA_WIDTH-1:0]   id_imm_i,
    input  logic                    id_alu_src_i,
    input  logic                    id_reg_write_i,
    input  logic                    id_mem_read_i,
    input  logic                    exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0]   exmem_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   exmem_alu_data_i,
    input  logic                    memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0]   memwb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]   memwb_data_i,
    output logic [3:0]              alu_operation_o,
    output logic [DATA_WIDTH-1:0]   a_o,
    output logic [DATA_WIDTH-1:0]   b_o,
    output logic [REG_ADDR_W-1:0]   rd_addr_o,
    output logic                    reg_write_o,
    output logic                    mem_read_o,
    output logic                    valid_o,
    output logic                    id_stall_o,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o
);

    localparam logic [BUBBLE_CNT_W-1:0] c_CNT_ONE = {{(BUBBLE_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BUBBLE_CNT_W-1:0] c_CNT_MAX = {BUBBLE_CNT_W{1'b1}};

    logic [3:0]              r_op;
    logic [REG_ADDR_W-1:0]   r_rs_addr;
    logic [REG_ADDR_W-1:0]   r_rt_addr;
    logic [DATA_WIDTH-1:0]   r_rs_data;
    logic [DATA_WIDTH-1:0]   r_rt_data;
    logic [DATA_WIDTH-1:0]   r_imm;
    logic                    r_alu_src;
    logic [REG_ADDR_W-1:0]   r_rd;
    logic                    r_reg_write;
    logic                    r_mem_read;
    logic                    r_rt_used;
    logic                    r_valid;
    logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

    logic                    w_rs_match_ex;
    logic                    w_rt_match_ex;
    logic                    w_load_use;
    logic                    w_hazard;
    logic [DATA_WIDTH-1:0]   w_a;
    logic [DATA_WIDTH-1:0]   w_b_reg;
    logic                    w_unused;

    // EX-stage destination against the sources of the instruction sitting in ID
    assign w_rs_match_ex = (r_rd != '0) && (r_rd == id_rs_addr_i);
    assign w_rt_match_ex = (r_rd != '0) && id_rt_used_i && (r_rd == id_rt_addr_i);
    assign w_load_use    = r_valid && r_mem_read && (w_rs_match_ex || w_rt_match_ex) && id_valid_i;

`ifdef ID_EX_FORWARD_EN
    function automatic logic [DATA_WIDTH-1:0] f_fwd(
        input logic [REG_ADDR_W-1:0] src,
        input logic [DATA_WIDTH-1:0] rf_val,
        input logic                  em_we,
        input logic [REG_ADDR_W-1:0] em_rd,
        input logic [DATA_WIDTH-1:0] em_val,
        input logic                  mw_we,
        input logic [REG_ADDR_W-1:0] mw_rd,
        input logic [DATA_WIDTH-1:0] mw_val
    );
        logic [DATA_WIDTH-1:0] v;
        v = rf_val;
        if (em_we && (em_rd != '0) && (em_rd == src))
            v = em_val;
        else if (mw_we && (mw_rd != '0) && (mw_rd == src))
            v = mw_val;
        return v;
    endfunction

    assign w_a      = f_fwd(r_rs_addr, r_rs_data, exmem_reg_write_i, exmem_rd_addr_i,
                            exmem_alu_data_i, memwb_reg_write_i, memwb_rd_addr_i, memwb_data_i);
    assign w_b_reg  = f_fwd(r_rt_addr, r_rt_data, exmem_reg_write_i, exmem_rd_addr_i,
                            exmem_alu_data_i, memwb_reg_write_i, memwb_rd_addr_i, memwb_data_i);
    assign w_hazard = w_load_use;
`else
    logic w_dep_ex;
    logic w_dep_exmem;

    // Without forwarding, wait until the producer has reached MEM/WB (write-before-read)
    assign w_dep_ex    = r_valid && r_reg_write && (w_rs_match_ex || w_rt_match_ex);
    assign w_dep_exmem = exmem_reg_write_i && (exmem_rd_addr_i != '0) &&
                         ((exmem_rd_addr_i == id_rs_addr_i) ||
                          (id_rt_used_i && (exmem_rd_addr_i == id_rt_addr_i)));
    assign w_a      = r_rs_data;
    assign w_b_reg  = r_rt_data;
    assign w_hazard = w_load_use || ((w_dep_ex || w_dep_exmem) && id_valid_i);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op         <= '0;
            r_rs_addr    <= '0;
            r_rt_addr    <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_alu_src    <= 1'b0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_rt_used    <= 1'b0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush_i) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_op        <= '0;
        end else if (!stall_i) begin
            if (w_hazard) begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_op        <= '0;
                if (r_bubble_cnt != c_CNT_MAX)
                    r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
            end else begin
                r_op        <= id_alu_operation_i;
                r_rs_addr   <= id_rs_addr_i;
                r_rt_addr   <= id_rt_addr_i;
                r_rs_data   <= id_rs_data_i;
                r_rt_data   <= id_rt_data_i;
                r_imm       <= id_imm_i;
                r_alu_src   <= id_alu_src_i;
                r_rd        <= id_rd_addr_i;
                r_reg_write <= id_reg_write_i;
                r_mem_read  <= id_mem_read_i;
                r_rt_used   <= id_rt_used_i;
                r_valid     <= id_valid_i;
            end
        end
    end

    assign a_o             = w_a;
    assign b_o             = r_alu_src ? r_imm : w_b_reg;
    assign alu_operation_o = r_valid ? r_op : 4'd0;
    assign rd_addr_o       = r_valid ? r_rd : '0;
    assign reg_write_o     = r_valid && r_reg_write;
    assign mem_read_o      = r_valid && r_mem_read;
    assign valid_o         = r_valid;
    assign id_stall_o      = reset && (stall_i || w_hazard);
    assign bubble_cnt_o    = r_bubble_cnt;

    // Some inputs/fields only matter in one build configuration
    assign w_unused = ^{r_rt_used, r_rs_addr, r_rt_addr, exmem_alu_data_i,
                        memwb_reg_write_i, memwb_rd_addr_i, memwb_data_i};

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Purpose  : Directed self-checking bench for id_ex_operand_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, flush_i, id_valid_i, id_rt_used_i;
    logic [3:0]  id_alu_operation_i;
    logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic        id_alu_src_i, id_reg_write_i, id_mem_read_i;
    logic        exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]  exmem_rd_addr_i, memwb_rd_addr_i;
    logic [31:0] exmem_alu_data_i, memwb_data_i;
    logic [3:0]  alu_operation_o;
    logic [31:0] a_o, b_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, mem_read_o, valid_o, id_stall_o;
    logic [15:0] bubble_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_bub  = 0;

    id_ex_operand_stage dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .id_valid_i         (id_valid_i),
        .id_alu_operation_i (id_alu_operation_i),
        .id_rs_addr_i       (id_rs_addr_i),
        .id_rt_addr_i       (id_rt_addr_i),
        .id_rt_used_i       (id_rt_used_i),
        .id_rd_addr_i       (id_rd_addr_i),
        .id_rs_data_i       (id_rs_data_i),
        .id_rt_data_i       (id_rt_data_i),
        .id_imm_i           (id_imm_i),
        .id_alu_src_i       (id_alu_src_i),
        .id_reg_write_i     (id_reg_write_i),
        .id_mem_read_i      (id_mem_read_i),
        .exmem_reg_write_i  (exmem_reg_write_i),
        .exmem_rd_addr_i    (exmem_rd_addr_i),
        .exmem_alu_data_i   (exmem_alu_data_i),
        .memwb_reg_write_i  (memwb_reg_write_i),
        .memwb_rd_addr_i    (memwb_rd_addr_i),
        .memwb_data_i       (memwb_data_i),
        .alu_operation_o    (alu_operation_o),
        .a_o                (a_o),
        .b_o                (b_o),
        .rd_addr_o          (rd_addr_o),
        .reg_write_o        (reg_write_o),
        .mem_read_o         (mem_read_o),
        .valid_o            (valid_o),
        .id_stall_o         (id_stall_o),
        .bubble_cnt_o       (bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // op, rs, rt, rt_used, rd, rs_data, rt_data, imm, alu_src, reg_write, mem_read
    task automatic set_id(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rt_used, input logic [4:0] rd, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [31:0] imm, input logic asrc,
                          input logic rw, input logic mr);
        id_valid_i         = 1'b1;
        id_alu_operation_i = op;
        id_rs_addr_i       = rs;
        id_rt_addr_i       = rt;
        id_rt_used_i       = rt_used;
        id_rd_addr_i       = rd;
        id_rs_data_i       = rsd;
        id_rt_data_i       = rtd;
        id_imm_i           = imm;
        id_alu_src_i       = asrc;
        id_reg_write_i     = rw;
        id_mem_read_i      = mr;
    endtask

    task automatic set_exmem(input logic we, input logic [4:0] rd, input logic [31:0] d);
        exmem_reg_write_i = we;
        exmem_rd_addr_i   = rd;
        exmem_alu_data_i  = d;
    endtask

    task automatic set_memwb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        memwb_reg_write_i = we;
        memwb_rd_addr_i   = rd;
        memwb_data_i      = d;
    endtask

    initial begin
        reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
        id_alu_operation_i = '0; id_rs_addr_i = '0; id_rt_addr_i = '0; id_rt_used_i = 1'b0;
        id_rd_addr_i = '0; id_rs_data_i = '0; id_rt_data_i = '0; id_imm_i = '0;
        id_alu_src_i = 1'b0; id_reg_write_i = 1'b0; id_mem_read_i = 1'b0;
        set_exmem(1'b0, 5'd0, 32'h0);
        set_memwb(1'b0, 5'd0, 32'h0);
        #2;
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_op", {28'b0, alu_operation_o}, 32'h0);
        check("rst_a", a_o, 32'h0);
        check("rst_b", b_o, 32'h0);
        check("rst_stall", {31'b0, id_stall_o}, 32'h0);
        check("rst_bub", {16'b0, bubble_cnt_o}, 32'h0);

        // ADD r3 = r1 + r2
        tick();
        reset = 1'b1;
        set_id(4'b0011, 5'd1, 5'd2, 1'b1, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        check("add_nostall", {31'b0, id_stall_o}, 32'h0);
        tick();
        check("add_valid", {31'b0, valid_o}, 32'h1);
        check("add_a", a_o, 32'd5);
        check("add_b", b_o, 32'd7);
        check("add_op", {28'b0, alu_operation_o}, 32'h3);
        check("add_rd", {27'b0, rd_addr_o}, 32'd3);
        check("add_rw", {31'b0, reg_write_o}, 32'h1);

        // Asynchronous reset mid-stream
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'b0, valid_o}, 32'h0);
        check("midrst_a", a_o, 32'h0);
        check("midrst_op", {28'b0, alu_operation_o}, 32'h0);
        check("midrst_rd", {27'b0, rd_addr_o}, 32'h0);
        reset = 1'b1;
        tick();
        check("rel_valid", {31'b0, valid_o}, 32'h1);
        check("rel_a", a_o, 32'd5);

        // SUB r4 = r3 - r1, dependent on the ADD in EX
        set_id(4'b0100, 5'd3, 5'd1, 1'b1, 5'd4, 32'h99, 32'd5, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef ID_EX_FORWARD_EN
        check("dep_nostall", {31'b0, id_stall_o}, 32'h0);
        tick();
        set_exmem(1'b1, 5'd3, 32'h10);
        #1;
        check("dep_fwd_valid", {31'b0, valid_o}, 32'h1);
        check("dep_fwd_a", a_o, 32'h10);
        check("dep_fwd_b", b_o, 32'd5);
        check("dep_fwd_bub", {16'b0, bubble_cnt_o}, 32'h0);
`else
        check("dep_stall1", {31'b0, id_stall_o}, 32'h1);
        tick();
        exp_bub = 1;
        check("dep_bub1_valid", {31'b0, valid_o}, 32'h0);
        check("dep_bub1_cnt", {16'b0, bubble_cnt_o}, exp_bub);
        set_exmem(1'b1, 5'd3, 32'h10);
        #1;
        check("dep_stall2", {31'b0, id_stall_o}, 32'h1);
        tick();
        exp_bub = 2;
        check("dep_bub2_valid", {31'b0, valid_o}, 32'h0);
        check("dep_bub2_cnt", {16'b0, bubble_cnt_o}, exp_bub);
        set_exmem(1'b0, 5'd0, 32'h0);
        set_memwb(1'b1, 5'd3, 32'h10);
        id_rs_data_i = 32'h10;
        #1;
        check("dep_stall3", {31'b0, id_stall_o}, 32'h0);
        tick();
        check("dep_valid", {31'b0, valid_o}, 32'h1);
        check("dep_a", a_o, 32'h10);
        check("dep_op", {28'b0, alu_operation_o}, 32'h4);
        check("dep_cnt", {16'b0, bubble_cnt_o}, exp_bub);
`endif

        // Forwarding priority on rs = r5
        set_exmem(1'b0, 5'd0, 32'h0);
        set_memwb(1'b0, 5'd0, 32'h0);
        set_id(4'b0011, 5'd5, 5'd0, 1'b1, 5'd8, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        set_exmem(1'b1, 5'd5, 32'hAAAA);
        set_memwb(1'b1, 5'd5, 32'h5555);
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd_both_a", a_o, 32'hAAAA);
`else
        check("fwd_both_a", a_o, 32'h1234);
`endif
        set_exmem(1'b0, 5'd5, 32'hAAAA);
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd_memwb_a", a_o, 32'h5555);
`else
        check("fwd_memwb_a", a_o, 32'h1234);
`endif
        set_exmem(1'b1, 5'd0, 32'hAAAA);
        set_memwb(1'b1, 5'd0, 32'h5555);
        #1;
        check("fwd_r0_a", a_o, 32'h1234);
        check("fwd_r0_b", b_o, 32'h0);
        set_exmem(1'b0, 5'd0, 32'h0);
        set_memwb(1'b0, 5'd0, 32'h0);

        // LW r6, 4(r1) followed by ADD r7 = r6 + r1
        set_id(4'b0011, 5'd1, 5'd0, 1'b0, 5'd6, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1);
        tick();
        check("lw_mr", {31'b0, mem_read_o}, 32'h1);
        check("lw_a", a_o, 32'h100);
        check("lw_b_imm", b_o, 32'h4);
        set_id(4'b0011, 5'd6, 5'd1, 1'b1, 5'd7, 32'h0, 32'd5, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        check("lu_stall", {31'b0, id_stall_o}, 32'h1);
        tick();
        exp_bub = exp_bub + 1;
        check("lu_bub_valid", {31'b0, valid_o}, 32'h0);
        check("lu_bub_rw", {31'b0, reg_write_o}, 32'h0);
        check("lu_bub_cnt", {16'b0, bubble_cnt_o}, exp_bub);
        set_exmem(1'b1, 5'd6, 32'h104);
        #1;
`ifdef ID_EX_FORWARD_EN
        check("lu_after_nostall", {31'b0, id_stall_o}, 32'h0);
        tick();
        set_exmem(1'b0, 5'd0, 32'h0);
        set_memwb(1'b1, 5'd6, 32'h77);
        #1;
`else
        check("lu_exmem_stall", {31'b0, id_stall_o}, 32'h1);
        tick();
        exp_bub = exp_bub + 1;
        check("lu_bub2_cnt", {16'b0, bubble_cnt_o}, exp_bub);
        set_exmem(1'b0, 5'd0, 32'h0);
        set_memwb(1'b1, 5'd6, 32'h77);
        id_rs_data_i = 32'h77;
        #1;
        check("lu_wb_nostall", {31'b0, id_stall_o}, 32'h0);
        tick();
`endif
        check("lu_use_valid", {31'b0, valid_o}, 32'h1);
        check("lu_use_a", a_o, 32'h77);
        check("lu_use_b", b_o, 32'd5);
        set_memwb(1'b0, 5'd0, 32'h0);

        // External stall holds, then flush wins over stall
        set_id(4'b0010, 5'd2, 5'd0, 1'b0, 5'd9, 32'h33, 32'h0, 32'hF0, 1'b1, 1'b1, 1'b0);
        stall_i = 1'b1;
        #1;
        check("stall_forced", {31'b0, id_stall_o}, 32'h1);
        tick();
        check("stall_hold_valid", {31'b0, valid_o}, 32'h1);
        check("stall_hold_op", {28'b0, alu_operation_o}, 32'h3);
        check("stall_hold_b", b_o, 32'd5);
        flush_i = 1'b1;
        tick();
        check("flush_valid", {31'b0, valid_o}, 32'h0);
        check("flush_op", {28'b0, alu_operation_o}, 32'h0);
        check("flush_rw", {31'b0, reg_write_o}, 32'h0);
        check("flush_cnt", {16'b0, bubble_cnt_o}, exp_bub);
        flush_i = 1'b0;
        stall_i = 1'b0;
        tick();
        check("or_valid", {31'b0, valid_o}, 32'h1);
        check("or_op", {28'b0, alu_operation_o}, 32'h2);
        check("or_a", a_o, 32'h33);
        check("or_b", b_o, 32'hF0);

`ifndef ID_EX_FORWARD_EN
        // Continuous dependency on r9 to drive the counter into saturation
        set_exmem(1'b1, 5'd9, 32'h0);
        set_id(4'b0011, 5'd9, 5'd0, 1'b0, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (65534 - exp_bub) tick();
        check("sat_fffe", {16'b0, bubble_cnt_o}, 32'hFFFE);
        repeat (3) tick();
        check("sat_ffff", {16'b0, bubble_cnt_o}, 32'hFFFF);
        check("sat_valid", {31'b0, valid_o}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
